// File: rtl/piso_shifter_param_if.sv
// rtl/piso_shifter_param_if.sv - load/serial bundle for piso_shifter_param; frame length follows PISO_PARITY_EN
interface piso_shifter_param_if #(
    parameter int WIDTH = 8
);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             q;
    logic             q_valid;
    logic             busy;
    logic             done;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output din, load,
        input  ready, q, q_valid, busy, done, bit_cnt
    );

    modport slave (
        input  din, load,
        output ready, q, q_valid, busy, done, bit_cnt
    );
endinterface

// File: rtl/piso_shifter_param.sv
// rtl/piso_shifter_param.sv - parametrised PISO shifter; PISO_PARITY_EN appends an even-parity bit per word
module piso_shifter_param #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter bit FILL      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_shifter_param_if.slave   bus
);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             q_r, q_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             last;
    logic             ready_int;
`ifdef PISO_PARITY_EN
    logic             par, par_n;
`endif

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], FILL} : {FILL, v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= {WIDTH{FILL}};
            q_r   <= 1'b0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            q_r   <= q_n;
            cnt   <= cnt_n;
`ifdef PISO_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // The first bit goes straight to q on load, so sreg only holds what is still to come.
    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        q_n       = q_r;
        cnt_n     = cnt;
`ifdef PISO_PARITY_EN
        par_n     = par;
`endif
        last      = (state == SHIFT) && (cnt == CW'(1));
        ready_int = (state == IDLE) || last;

        if (bus.load && ready_int) begin
            state_n = SHIFT;
            q_n     = out_bit(bus.din);
            sreg_n  = shift1(bus.din);
            cnt_n   = CW'(FRAME);
`ifdef PISO_PARITY_EN
            par_n   = ^bus.din;
`endif
        end else if (state == SHIFT) begin
            if (last) begin
                state_n = IDLE;
                q_n     = 1'b0;
                cnt_n   = '0;
            end else begin
                cnt_n  = cnt - CW'(1);
                q_n    = out_bit(sreg);
                sreg_n = shift1(sreg);
`ifdef PISO_PARITY_EN
                if (cnt == CW'(2)) begin
                    q_n = par;
                end
`endif
            end
        end
    end

    assign bus.ready   = ready_int;
    assign bus.q       = q_r;
    assign bus.q_valid = (state == SHIFT);
    assign bus.busy    = (state == SHIFT);
    assign bus.done    = last;
    assign bus.bit_cnt = cnt;
endmodule

// File: tb/tb_piso_shifter_param.sv
// tb/tb_piso_shifter_param.sv - checks MSB-first and LSB-first shifters against a bit-queue reference model
module tb_piso_shifter_param;
    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Each queue holds the bits still due on q, front = the bit on q now.
    bit qm[$];
    bit ql[$];

    always #5 clk = ~clk;

    piso_shifter_param_if #(.WIDTH(WIDTH)) bus_m ();
    piso_shifter_param_if #(.WIDTH(WIDTH)) bus_l ();

    piso_shifter_param #(.WIDTH(WIDTH), .MSB_FIRST(1), .FILL(1'b0)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    piso_shifter_param #(.WIDTH(WIDTH), .MSB_FIRST(0), .FILL(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        int sm;
        int sl;
        sm = qm.size();
        sl = ql.size();
        check("m.q",       32'(bus_m.q),       (sm > 0) ? 32'(qm[0]) : 32'd0);
        check("m.q_valid", 32'(bus_m.q_valid), 32'(sm > 0));
        check("m.busy",    32'(bus_m.busy),    32'(sm > 0));
        check("m.done",    32'(bus_m.done),    32'(sm == 1));
        check("m.ready",   32'(bus_m.ready),   32'(sm <= 1));
        check("m.bit_cnt", 32'(bus_m.bit_cnt), 32'(sm));
        check("l.q",       32'(bus_l.q),       (sl > 0) ? 32'(ql[0]) : 32'd0);
        check("l.q_valid", 32'(bus_l.q_valid), 32'(sl > 0));
        check("l.done",    32'(bus_l.done),    32'(sl == 1));
        check("l.ready",   32'(bus_l.ready),   32'(sl <= 1));
        check("l.bit_cnt", 32'(bus_l.bit_cnt), 32'(sl));
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d);
        for (int i = 0; i < WIDTH; i++) begin
            qm.push_back(d[WIDTH-1-i]);
            ql.push_back(d[i]);
        end
`ifdef PISO_PARITY_EN
        qm.push_back(^d);
        ql.push_back(^d);
`endif
    endtask

    task automatic tick(input logic l, input logic [WIDTH-1:0] d, input logic r);
        bit acc;
        bus_m.load = l;
        bus_m.din  = d;
        bus_l.load = l;
        bus_l.din  = d;
        rst        = r;
        acc        = l && (qm.size() <= 1);
        @(posedge clk);
        cyc++;
        if (r) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc) push_frame(d);
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        bus_m.load = 1'b0;
        bus_m.din  = '0;
        bus_l.load = 1'b0;
        bus_l.din  = '0;

        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h55, 1'b1);

        tick(1'b1, 8'hA5, 1'b0);
        idle(FRAME + 2);
        tick(1'b1, 8'h01, 1'b0);
        idle(FRAME + 2);

        tick(1'b1, 8'hFF, 1'b0);
        idle(FRAME - 1);
        tick(1'b1, 8'h00, 1'b0);
        idle(FRAME + 2);

        tick(1'b1, 8'hF0, 1'b0);
        idle(2);
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        idle(FRAME + 2);

        tick(1'b1, 8'hC3, 1'b0);
        idle(3);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h81, 1'b0);
        idle(FRAME + 2);

        tick(1'b1, 8'h07, 1'b0);
        idle(FRAME + 1);
        tick(1'b1, 8'h03, 1'b0);
        idle(FRAME + 1);

        for (int i = 0; i < 500; i++) begin
            tick(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 WIDTH'($urandom),
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end
        idle(FRAME + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
